// File: rtl/hex_display_scroller.sv
// hex_display_scroller
//   Drives NUM_DIGITS active-low seven-segment digits from a DATA_WIDTH-bit
//   value. It supports live, hold and scroll display modes, leading-zero
//   blanking, and blinking. A free-running tick of TICK_DIV cycles paces
//   both the scrolling and the blinking.
//
// Ports
//   Clock        : rising-edge clock
//   Reset        : asynchronous, active-high reset
//   Data         : value to display
//   Load         : single-cycle capture strobe (used in hold/scroll/reserved)
//   Mode         : 00 live, 01 hold, 10 scroll, 11 reserved (acts as hold)
//   BlankLZ      : blank digits above the highest non-zero displayed nibble
//   Blink        : blank the whole display while the blink phase is set
//   SegOut       : registered segments; digit k at [7k+6:7k], bit 0 = a
//   WindowOffset : nibble index shown on digit 0
//   Tick         : one-cycle pulse every TICK_DIV cycles
module hex_display_scroller #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned TICK_DIV   = 6750000,
  localparam int unsigned NIBBLES   = DATA_WIDTH / 4,
  localparam int unsigned OFF_W     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [DATA_WIDTH-1:0]     Data,
  input  logic                      Load,
  input  logic [1:0]                Mode,
  input  logic                      BlankLZ,
  input  logic                      Blink,
  output logic [7*NUM_DIGITS-1:0]   SegOut,
  output logic [OFF_W-1:0]          WindowOffset,
  output logic                      Tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [OFF_W-1:0] MAX_OFF = OFF_W'(NIBBLES - NUM_DIGITS);

  typedef enum logic [1:0] {
    MODE_LIVE   = 2'b00,
    MODE_HOLD   = 2'b01,
    MODE_SCROLL = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  mode_e                   mode;
  mode_e                   mode_q;
  logic [DATA_WIDTH-1:0]   shown;
  logic [CNT_W-1:0]        tick_cnt;
  logic                    phase;
  logic                    restart;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   nz;
  logic [7*NUM_DIGITS-1:0] seg_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
    endcase
  endfunction

  assign mode = mode_e'(Mode);
  assign Tick = (tick_cnt == CNT_MAX);

  // A mode change, or a fresh capture while scrolling, restarts the window
  // and the tick phase so the new content is shown from its start.
  assign restart = (mode != mode_q) || ((mode == MODE_SCROLL) && Load);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shown  <= '0;
      mode_q <= MODE_LIVE;
    end else begin
      mode_q <= mode;
      if ((mode == MODE_LIVE) || Load) begin
        shown <= Data;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tick_cnt <= '0;
    end else if (restart || Tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      phase <= 1'b0;
    end else if (Tick) begin
      phase <= ~phase;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      WindowOffset <= '0;
    end else if (restart || (mode != MODE_SCROLL)) begin
      WindowOffset <= '0;
    end else if (Tick) begin
      WindowOffset <= (WindowOffset == MAX_OFF) ? '0 : WindowOffset + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [IDX_W-1:0] base;
    logic             blank;

    assign base  = IDX_W'({WindowOffset, 2'b00}) + IDX_W'(4 * k);
    assign nib[k] = shown[base +: 4];
    assign nz[k]  = |nib[k];
    // Leading-zero blank: no non-zero nibble at this digit or any above it.
    assign blank = (Blink && phase) ||
                   (BlankLZ && (k != 0) && !(|nz[NUM_DIGITS-1:k]));
    assign seg_next[7*k +: 7] = blank ? '1 : hex7(nib[k]);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      SegOut <= '1;
    end else begin
      SegOut <= seg_next;
    end
  end

endmodule

// File: doc/hex_display_scroller.md
HEX_DISPLAY_SCROLLER -- requirements
Module: hex_display_scroller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of value to display; multiple of 4 and >= 4*NUM_DIGITS.
REQ-002 SHALL have parameter NUM_DIGITS, default 8: number of seven-segment digits driven.
REQ-003 SHALL have parameter TICK_DIV, default 6750000: Clock cycles per scroll/blink tick (4 Hz at 27 MHz); >= 2.
REQ-004 SHALL have port Clock, input, 1: single clock, rising edge.
REQ-005 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port Data, input, DATA_WIDTH: value to display.
REQ-007 SHALL have port Load, input, 1: single-cycle capture strobe.
REQ-008 SHALL have port Mode, input, 2: 00 live, 01 hold, 10 scroll, 11 reserved (treated as hold).
REQ-009 SHALL have port BlankLZ, input, 1: enable leading-zero blanking.
REQ-010 SHALL have port Blink, input, 1: enable display blinking.
REQ-011 SHALL have port SegOut, output, 7*NUM_DIGITS: active-low segments; digit k occupies [7k+6:7k], bit 0 = a ... bit 6 = g.
REQ-012 SHALL have port WindowOffset, output, clog2(DATA_WIDTH/4) (min 1): nibble index shown on digit 0.
REQ-013 SHALL have port Tick, output, 1: one-cycle pulse each TICK_DIV cycles.

Function
REQ-014 SHALL keep a shown register (DATA_WIDTH): live mode loads Data every cycle; hold, reserved and scroll modes load Data only on cycles with Load=1.
REQ-015 SHALL drive digit k from shown nibble (WindowOffset+k); offset+k never exceeds DATA_WIDTH/4-1.
REQ-016 SHALL register SegOut: Data-to-SegOut latency 2 cycles in live mode; Load-to-SegOut latency 2 cycles otherwise.
REQ-017 SHALL encode hex active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (bit 6..0); blank=1111111.
REQ-018 SHALL run a tick counter 0..TICK_DIV-1, pulsing Tick on the cycle it wraps to 0, free-running in all modes.
REQ-019 In scroll mode, SHALL increment WindowOffset by 1 on each Tick, wrapping from DATA_WIDTH/4-NUM_DIGITS to 0.
REQ-020 When DATA_WIDTH/4 == NUM_DIGITS, WindowOffset SHALL remain 0 in all modes.
REQ-021 Outside scroll mode, WindowOffset SHALL be 0.
REQ-022 Any change of Mode SHALL, on the next edge, clear WindowOffset and tick counter; Load in the same cycle is still honoured.
REQ-023 Load in scroll mode SHALL also clear WindowOffset and tick counter.
REQ-024 With BlankLZ=1, digits above the highest non-zero displayed nibble SHALL be blank; digit 0 never blanked by this rule.
REQ-025 SHALL toggle a blink phase bit on every Tick; with Blink=1 and phase=1, all digits blank; Blink=0 shows normally regardless of phase.

Reset
REQ-026 While Reset=1: shown=0, WindowOffset=0, tick counter=0, blink phase=0, Tick=0, SegOut all ones (blank).
REQ-027 Reset asserted mid-scroll SHALL abort immediately; after release the first valid SegOut appears 2 cycles after the first capture per REQ-014.

Verification (bench: DATA_WIDTH=32, NUM_DIGITS=4, TICK_DIV=4)
REQ-028 Live: Data=0x0000ABCD, Mode=00 -> 2 cycles later digits 3..0 show A,b,C,d; WindowOffset=0.
REQ-029 Hold: Mode=01, Load with Data=0x00001234, then Data=0xFFFFFFFF without Load -> display stays 1,2,3,4.
REQ-030 Scroll: Mode=10, Load 0x12345678 -> WindowOffset 0,1,2,3,4,0 at successive Ticks; at offset 4 digits 3..0 show 1,2,3,4.
REQ-031 Blanking: Mode=00, BlankLZ=1, Data=0x00000007 -> digits 3..1 = 1111111, digit 0 = 7; Data=0 -> only digit 0 shows 0.
REQ-032 Blink and mode change: Blink=1 -> display alternates blank/visible every 4 cycles; switching Mode 10->01 at offset 3 -> next cycle WindowOffset=0, tick counter=0.
REQ-033 Reset: assert Reset at offset 2 mid-scroll -> same cycle SegOut all ones, WindowOffset=0, Tick=0.
